// File: rtl/memory_array.sv
// Single-port synchronous memory for the 6502 bus: valid/ready requests, fixed-latency
// responses, write-protected ROM window, range errors and a post-reset zero-fill sequencer.
// Optional macro MEMORY_ARRAY_INIT_FILE_EN: skip the zero-fill so contents survive reset.
module memory_array #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH_LOG2 = 12,
  parameter int                    RD_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hF000,
  parameter logic [ADDR_WIDTH-1:0] ROM_TOP    = 16'hFFFF,
  parameter string                 INIT_FILE  = "NONE"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ROM_SPAN = ROM_TOP - ROM_BASE;

`ifdef MEMORY_ARRAY_INIT_FILE_EN
  localparam logic [0:0] ST_AFTER_RESET = ST_READY;
`else
  localparam logic [0:0] ST_AFTER_RESET = ST_CLEAR;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] clear_addr;

  logic                  accept;
  logic                  in_range;
  logic                  in_rom;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] rom_off;
  logic [DEPTH_LOG2-1:0] req_idx;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  pipe_valid [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data  [RD_LATENCY];
  logic                  pipe_err   [RD_LATENCY];

  logic unused_init_file;
  assign unused_init_file = (INIT_FILE == "NONE");

  assign req_ready = (state == ST_READY);
  assign busy      = (state == ST_CLEAR);
  assign req_idx   = req_addr[DEPTH_LOG2-1:0];

  // Window test by offset subtraction keeps it a single compare and stays correct
  // when the window touches either end of the address space.
  assign rom_off   = req_addr - ROM_BASE;

  always_comb begin
    in_range  = ((req_addr >> DEPTH_LOG2) == '0);
    in_rom    = (rom_off <= ROM_SPAN);
    accept    = req_valid && req_ready;
    wr_ok     = accept && req_we && in_range && !in_rom;
    rd_ok     = accept && !req_we && in_range;
    req_err   = !in_range || (req_we && in_rom);

    mem_we    = 1'b0;
    mem_addr  = req_idx;
    mem_wdata = req_wdata;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clear_addr;
        mem_wdata = '0;
      end else begin
        mem_we    = wr_ok;
      end
    end
  end

  // NOTE: the storage array has no reset branch so it maps onto block RAM; its
  // contents are defined by the zero-fill sequencer instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_AFTER_RESET;
      clear_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clear_addr <= clear_addr + 1'b1;
      if (clear_addr == '1) begin
        state <= ST_READY;
      end
    end
  end

  // Stage 0 is the registered array read; later stages only move when their input
  // is valid, so the last stage holds the previous response while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      if (accept) begin
        pipe_data[0] <= rd_ok ? mem[req_idx] : '0;
        pipe_err[0]  <= req_err;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_err[i]  <= pipe_err[i-1];
        end
      end
    end
  end

  assign rsp_valid = pipe_valid[RD_LATENCY-1];
  assign rsp_rdata = pipe_data[RD_LATENCY-1];
  assign rsp_err   = pipe_err[RD_LATENCY-1];

endmodule

// File: tb/tb_memory_array.sv
// Randomized self-checking bench for memory_array: reference memory model plus an
// in-order expected-response queue stamped with the cycle each response is due.
module tb_memory_array;

  localparam int                DW     = 8;
  localparam int                AW     = 16;
  localparam int                DL2    = 12;
  localparam int                LAT    = 3;
  localparam int                DEPTH  = 1 << DL2;
  localparam logic [AW-1:0]     ROM_B  = 16'h0E00;
  localparam logic [AW-1:0]     ROM_T  = 16'h0EFF;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cycle;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  int            cycle_cnt = 0;
  int            ready_cycle = 32'h7fff_ffff;

  logic [DW-1:0] model_mem [DEPTH];
  rsp_t          exp_q [$];
  logic [DW-1:0] hold_rdata = '0;
  logic          hold_err = 1'b0;

  memory_array #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_LOG2 (DL2),
    .RD_LATENCY (LAT),
    .ROM_BASE   (ROM_B),
    .ROM_TOP    (ROM_T),
    .INIT_FILE  ("NONE")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Response scoreboard: order, timing, payload, and hold-while-idle.
  always @(negedge clk) begin
    rsp_t e;
    while (exp_q.size() > 0 && exp_q[0].cycle < cycle_cnt) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp: no rsp_valid at cycle %0d, expected rdata=%h err=%b", e.cycle, e.rdata, e.err);
    end
    if (rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d with nothing outstanding", cycle_cnt);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cycle_cnt != e.cycle) begin
          errors++;
          $display("FAIL rsp: got rdata=%h err=%b at cycle %0d, expected rdata=%h err=%b at cycle %0d",
                   rsp_rdata, rsp_err, cycle_cnt, e.rdata, e.err, e.cycle);
        end
        hold_rdata = e.rdata;
        hold_err   = e.err;
      end
    end else if (reset === 1'b0) begin
      checks++;
      if (rsp_rdata !== hold_rdata || rsp_err !== hold_err) begin
        errors++;
        $display("FAIL rsp_hold: cycle %0d got rdata=%h err=%b, expected held rdata=%h err=%b",
                 cycle_cnt, rsp_rdata, rsp_err, hold_rdata, hold_err);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b1;
    req_valid   = 1'b0;
    ready_cycle = cycle_cnt + 1 + DEPTH;
    #1;
    exp_q.delete();
    hold_rdata = '0;
    hold_err   = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    rsp_t e;
    logic exp_acc;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    exp_acc   = (cycle_cnt >= ready_cycle);
    checks++;
    if (req_ready !== exp_acc) begin
      errors++;
      $display("FAIL req_ready: cycle %0d got %b expected %b", cycle_cnt, req_ready, exp_acc);
    end
    if (exp_acc) begin
      e.cycle = cycle_cnt + LAT;
      e.rdata = '0;
      e.err   = 1'b0;
      if (int'(addr) >= DEPTH) begin
        e.err = 1'b1;
      end else if (we) begin
        if (addr >= ROM_B && addr <= ROM_T) e.err = 1'b1;
        else model_mem[int'(addr)] = wdata;
      end else begin
        e.rdata = model_mem[int'(addr)];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    idle(1);
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d responses still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_fill_duration(input string name);
    int n;
    logic seen_rsp;
    n = 0;
    seen_rsp = 1'b0;
    while (busy === 1'b1 && n < DEPTH + 100) begin
      if (rsp_valid === 1'b1) seen_rsp = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL %s_busy_len: busy lasted %0d cycles, expected %0d", name, n, DEPTH);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_after_fill: req_ready=%b expected 1", name, req_ready);
    end
    checks++;
    if (seen_rsp) begin
      errors++;
      $display("FAIL %s_rsp_during_fill: rsp_valid seen=1 expected 0", name);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
  endtask

  task automatic test_zero_fill();
    check_fill_duration("zero_fill");
    for (int a = 0; a < 16; a++) do_req(1'b0, AW'(a), '0);
    do_req(1'b0, AW'(DEPTH - 1), '0);
    drain("zero_fill");
  endtask

  task automatic test_write_read();
    int c;
    do_req(1'b1, 16'h0123, 8'h5A);
    c = cycle_cnt;
    do_req(1'b0, 16'h0123, 8'h00);
    idle(1);
    @(negedge clk);
    checks++;
    if (cycle_cnt != c + LAT || rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: cycle %0d valid=%b rdata=%h err=%b, expected cycle %0d valid=1 rdata=00 err=0",
               cycle_cnt, rsp_valid, rsp_rdata, rsp_err, c + LAT);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_wr: valid=%b rdata=%h err=%b, expected valid=1 rdata=5a err=0", rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL idle_hold: valid=%b rdata=%h, expected valid=0 rdata=5a", rsp_valid, rsp_rdata);
    end
    drain("write_read");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(16'h0200 + i), DW'(8'h30 + i));
    for (int i = 0; i < 16; i++) do_req(1'b0, AW'(16'h0200 + i), '0);
    drain("back_to_back");
  endtask

  task automatic test_rom_protect();
    do_req(1'b1, ROM_B, 8'hAA);
    do_req(1'b1, ROM_T, 8'hAA);
    do_req(1'b0, ROM_B, '0);
    do_req(1'b0, ROM_T, '0);
    do_req(1'b1, ROM_B - 16'h1, 8'hBB);
    do_req(1'b0, ROM_B - 16'h1, '0);
    do_req(1'b1, ROM_T + 16'h1, 8'hCC);
    do_req(1'b0, ROM_T + 16'h1, '0);
    do_req(1'b1, 16'hF000, 8'hAA);
    do_req(1'b1, 16'hFFFF, 8'hAA);
    drain("rom_protect");
  endtask

  task automatic test_range();
    do_req(1'b0, AW'(DEPTH), '0);
    do_req(1'b1, AW'(DEPTH), 8'h77);
    do_req(1'b0, 16'h0000, '0);
    do_req(1'b1, AW'(DEPTH - 1), 8'h99);
    do_req(1'b0, AW'(DEPTH - 1), '0);
    do_req(1'b0, 16'hFFFF, '0);
    drain("range");
  endtask

  task automatic test_random();
    logic [AW-1:0] addr;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: addr = AW'($urandom_range(0, 63));
        5:             addr = AW'($urandom_range(0, DEPTH - 1));
        6:             addr = AW'($urandom_range(int'(ROM_B) - 2, int'(ROM_T) + 2));
        7:             addr = AW'($urandom_range(DEPTH, 16'hFFFF));
        default:       addr = AW'($urandom_range(DEPTH - 2, DEPTH + 1));
      endcase
      do_req(1'($urandom_range(0, 1)), addr, DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain("random");
  endtask

  task automatic test_reset_midflight();
    do_req(1'b1, 16'h0040, 8'hE1);
    do_req(1'b0, 16'h0040, '0);
    do_req(1'b0, 16'h0041, '0);
    do_req(1'b0, 16'h0042, '0);
    apply_reset();
    for (int i = 0; i < 5; i++) do_req(1'b0, 16'h0040, '0);
    idle(DEPTH / 2);
    apply_reset();
    check_fill_duration("mid_clear");
    do_req(1'b0, 16'h0040, '0);
    do_req(1'b0, 16'h0123, '0);
    do_req(1'b0, ROM_B - 16'h1, '0);
    do_req(1'b0, AW'(DEPTH - 1), '0);
    drain("reset_midflight");
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    test_reset();
    test_zero_fill();
    test_write_read();
    test_back_to_back();
    test_rom_protect();
    test_range();
    test_random();
    test_reset_midflight();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
